dds_cmd_parser: RTL and testbench

- Byte-stream command decoder between the Ethernet/UDP receive path and the per-channel DDS top blocks.
- Parses fixed 7-byte command frames and checks the checksum, channel index, parameter ID and value range.
- A good frame produces a one-cycle parameter write (value + valid) toward the DDS channels; a bad frame produces an error code and no write.
- Always ready, no backpressure. Several commands may share one UDP packet.

---
 rtl/dds_pkg.sv | 64 ++++++
 rtl/dds_cmd_check.sv | 50 +++++
 rtl/dds_cmd_parser.sv | 213 +++++++++++++++++++++
 tb/tb_dds_cmd_parser.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants, range table and FSM encoding for the DDS command parser.
package dds_pkg;

    // Frame framing bytes and broadcast channel index
    localparam logic [7:0] C_HEAD1    = 8'h55;
    localparam logic [7:0] C_HEAD2    = 8'hAA;
    localparam logic [7:0] C_CH_BCAST = 8'hFF;

    // Parameter IDs
    localparam logic [2:0] C_ID_RUN    = 3'd0;
    localparam logic [2:0] C_ID_TYPE   = 3'd1;
    localparam logic [2:0] C_ID_FRQ    = 3'd2;
    localparam logic [2:0] C_ID_AMP    = 3'd3;
    localparam logic [2:0] C_ID_P2P    = 3'd4;
    localparam logic [2:0] C_ID_OFFSET = 3'd5;
    localparam logic [2:0] C_ID_PHASE  = 3'd6;
    localparam logic [2:0] C_ID_DUTY   = 3'd7;

    // Inclusive upper limits per field
    localparam logic [15:0] C_LIM_RUN    = 16'd1;
    localparam logic [15:0] C_LIM_TYPE   = 16'd7;
    localparam logic [15:0] C_LIM_FRQ    = 16'd50000;
    localparam logic [15:0] C_LIM_AMP    = 16'd3000;
    localparam logic [15:0] C_LIM_P2P    = 16'd6000;
    localparam logic [15:0] C_LIM_OFFSET = 16'd6000;
    localparam logic [15:0] C_LIM_PHASE  = 16'd3600;
    localparam logic [15:0] C_LIM_DUTY   = 16'd1000;

    // Error codes
    localparam logic [2:0] C_ERR_NONE    = 3'd0;
    localparam logic [2:0] C_ERR_CS      = 3'd1;
    localparam logic [2:0] C_ERR_CH      = 3'd2;
    localparam logic [2:0] C_ERR_ID      = 3'd3;
    localparam logic [2:0] C_ERR_RANGE   = 3'd4;
    localparam logic [2:0] C_ERR_TRUNC   = 3'd5;
    localparam logic [2:0] C_ERR_TIMEOUT = 3'd6;

    typedef enum logic [2:0] {
        S_HEAD1,
        S_HEAD2,
        S_CH,
        S_ID,
        S_VH,
        S_VL,
        S_CS
    } state_t;

    // Range limit lookup for a (valid) parameter ID
    function automatic logic [15:0] f_limit(input logic [2:0] id);
        logic [15:0] lim;
        case (id)
            C_ID_RUN:    lim = C_LIM_RUN;
            C_ID_TYPE:   lim = C_LIM_TYPE;
            C_ID_FRQ:    lim = C_LIM_FRQ;
            C_ID_AMP:    lim = C_LIM_AMP;
            C_ID_P2P:    lim = C_LIM_P2P;
            C_ID_OFFSET: lim = C_LIM_OFFSET;
            C_ID_PHASE:  lim = C_LIM_PHASE;
            default:     lim = C_LIM_DUTY;
        endcase
        return lim;
    endfunction

endpackage

// File: rtl/dds_cmd_check.sv
// Combinational frame validation: checksum, channel, ID and value range.
module dds_cmd_check
    import dds_pkg::*;
#(
    parameter int unsigned P_CH_NUM = 2
) (
    input  logic [7:0]          i_ch,
    input  logic [7:0]          i_id,
    input  logic [15:0]         i_val,
    input  logic [7:0]          i_cs,
    output logic                o_ok,
    output logic [2:0]          o_err_code,
    output logic [P_CH_NUM-1:0] o_ch_mask
);

    logic [7:0] w_sum;
    logic       w_bcast;
    logic       w_ch_ok;
    logic       w_id_ok;
    logic       w_range_ok;

    assign w_sum      = i_ch + i_id + i_val[15:8] + i_val[7:0];
    assign w_bcast    = (i_ch == C_CH_BCAST);
    assign w_ch_ok    = w_bcast || (32'(i_ch) < P_CH_NUM);
    assign w_id_ok    = (i_id < 8'd8);
    assign w_range_ok = (i_val <= f_limit(i_id[2:0]));

    // Channel one-hot, or all ones for broadcast
    always_comb begin
        o_ch_mask = '0;
        if (w_bcast) begin
            o_ch_mask = '1;
        end else begin
            for (int i = 0; i < int'(P_CH_NUM); i++) begin
                if (i_ch == 8'(i)) o_ch_mask[i] = 1'b1;
            end
        end
    end

    // First failing check wins
    always_comb begin
        o_err_code = C_ERR_NONE;
        if (w_sum != i_cs)     o_err_code = C_ERR_CS;
        else if (!w_ch_ok)     o_err_code = C_ERR_CH;
        else if (!w_id_ok)     o_err_code = C_ERR_ID;
        else if (!w_range_ok)  o_err_code = C_ERR_RANGE;
        o_ok = (o_err_code == C_ERR_NONE);
    end

endmodule

// File: rtl/dds_cmd_parser.sv
// Byte-stream parser for 7-byte DDS command frames; emits per-channel parameter writes.
module dds_cmd_parser
    import dds_pkg::*;
#(
    parameter int unsigned P_CH_NUM  = 2,
    parameter int unsigned P_TIMEOUT = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_rx_last,
    output logic                o_dds_run,
    output logic [2:0]          o_dds_type,
    output logic [15:0]         o_dds_frq,
    output logic [11:0]         o_dds_amp,
    output logic [12:0]         o_dds_p2p,
    output logic [12:0]         o_dds_offset,
    output logic [11:0]         o_dds_phase,
    output logic [9:0]          o_dds_duty,
    output logic [P_CH_NUM-1:0] o_run_vld,
    output logic [P_CH_NUM-1:0] o_type_vld,
    output logic [P_CH_NUM-1:0] o_frq_vld,
    output logic [P_CH_NUM-1:0] o_amp_vld,
    output logic [P_CH_NUM-1:0] o_p2p_vld,
    output logic [P_CH_NUM-1:0] o_offset_vld,
    output logic [P_CH_NUM-1:0] o_phase_vld,
    output logic [P_CH_NUM-1:0] o_duty_vld,
    output logic                o_err,
    output logic [2:0]          o_err_code,
    output logic [15:0]         o_ok_cnt,
    output logic [15:0]         o_err_cnt
);

    localparam int unsigned L_TW = $clog2(P_TIMEOUT + 1);
    localparam logic [L_TW-1:0] L_TO_LAST = L_TW'(P_TIMEOUT - 1);

    state_t r_state, w_state_d;
    logic [7:0]  r_ch, r_id, r_vh, r_vl;
    logic [L_TW-1:0] r_idle;

    logic w_done, w_trunc, w_timeout;
    logic w_ok;
    logic [2:0] w_chk_code;
    logic [P_CH_NUM-1:0] w_mask;
    logic [15:0] w_val;

    logic                          r_run;
    logic [2:0]                    r_type;
    logic [15:0]                   r_frq;
    logic [11:0]                   r_amp;
    logic [12:0]                   r_p2p;
    logic [12:0]                   r_offset;
    logic [11:0]                   r_phase;
    logic [9:0]                    r_duty;
    logic [7:0][P_CH_NUM-1:0]      r_vld;
    logic                          r_err;
    logic [2:0]                    r_err_code;
    logic [15:0]                   r_ok_cnt;
    logic [15:0]                   r_err_cnt;

    assign w_val = {r_vh, r_vl};

    // The CS byte is checked live, so the result lands one cycle after it
    dds_cmd_check #(
        .P_CH_NUM (P_CH_NUM)
    ) u_check (
        .i_ch       (r_ch),
        .i_id       (r_id),
        .i_val      (w_val),
        .i_cs       (i_rx_data),
        .o_ok       (w_ok),
        .o_err_code (w_chk_code),
        .o_ch_mask  (w_mask)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_HEAD1;
        else       r_state <= w_state_d;
    end

    // Next state plus frame-done / abort events; a byte beats a timeout
    always_comb begin
        w_state_d = r_state;
        w_done    = 1'b0;
        w_trunc   = 1'b0;
        w_timeout = 1'b0;
        if (i_rx_valid) begin
            case (r_state)
                S_HEAD1: if (i_rx_data == C_HEAD1) w_state_d = S_HEAD2;
                S_HEAD2: begin
                    if (i_rx_last) begin
                        w_trunc   = 1'b1;
                        w_state_d = S_HEAD1;
                    end else if (i_rx_data == C_HEAD2) begin
                        w_state_d = S_CH;
                    end else if (i_rx_data != C_HEAD1) begin
                        w_state_d = S_HEAD1;
                    end
                end
                S_CH, S_ID, S_VH, S_VL: begin
                    if (i_rx_last) begin
                        w_trunc   = 1'b1;
                        w_state_d = S_HEAD1;
                    end else begin
                        case (r_state)
                            S_CH:    w_state_d = S_ID;
                            S_ID:    w_state_d = S_VH;
                            S_VH:    w_state_d = S_VL;
                            default: w_state_d = S_CS;
                        endcase
                    end
                end
                S_CS: begin
                    w_done    = 1'b1;
                    w_state_d = S_HEAD1;
                end
                default: w_state_d = S_HEAD1;
            endcase
        end else if (r_state != S_HEAD1 && r_idle == L_TO_LAST) begin
            w_timeout = 1'b1;
            w_state_d = S_HEAD1;
        end
    end

    // Field capture and inter-byte idle counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ch   <= '0;
            r_id   <= '0;
            r_vh   <= '0;
            r_vl   <= '0;
            r_idle <= '0;
        end else begin
            if (i_rx_valid) begin
                case (r_state)
                    S_CH:    r_ch <= i_rx_data;
                    S_ID:    r_id <= i_rx_data;
                    S_VH:    r_vh <= i_rx_data;
                    S_VL:    r_vl <= i_rx_data;
                    default: ;
                endcase
            end
            if (i_rx_valid || w_state_d == S_HEAD1) r_idle <= '0;
            else                                    r_idle <= r_idle + 1'b1;
        end
    end

    // Registered write strobes, value buses, error reporting and counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_run      <= '0;
            r_type     <= '0;
            r_frq      <= '0;
            r_amp      <= '0;
            r_p2p      <= '0;
            r_offset   <= '0;
            r_phase    <= '0;
            r_duty     <= '0;
            r_vld      <= '0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_ok_cnt   <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_vld <= '0;
            r_err <= 1'b0;
            if (w_done && w_ok) begin
                r_vld[r_id[2:0]] <= w_mask;
                case (r_id[2:0])
                    C_ID_RUN:    r_run    <= w_val[0];
                    C_ID_TYPE:   r_type   <= w_val[2:0];
                    C_ID_FRQ:    r_frq    <= w_val;
                    C_ID_AMP:    r_amp    <= w_val[11:0];
                    C_ID_P2P:    r_p2p    <= w_val[12:0];
                    C_ID_OFFSET: r_offset <= w_val[12:0];
                    C_ID_PHASE:  r_phase  <= w_val[11:0];
                    default:     r_duty   <= w_val[9:0];
                endcase
                if (r_ok_cnt != 16'hFFFF) r_ok_cnt <= r_ok_cnt + 16'd1;
            end else if (w_done || w_trunc || w_timeout) begin
                r_err <= 1'b1;
                if (w_done)       r_err_code <= w_chk_code;
                else if (w_trunc) r_err_code <= C_ERR_TRUNC;
                else              r_err_code <= C_ERR_TIMEOUT;
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign o_dds_run    = r_run;
    assign o_dds_type   = r_type;
    assign o_dds_frq    = r_frq;
    assign o_dds_amp    = r_amp;
    assign o_dds_p2p    = r_p2p;
    assign o_dds_offset = r_offset;
    assign o_dds_phase  = r_phase;
    assign o_dds_duty   = r_duty;
    assign o_run_vld    = r_vld[C_ID_RUN];
    assign o_type_vld   = r_vld[C_ID_TYPE];
    assign o_frq_vld    = r_vld[C_ID_FRQ];
    assign o_amp_vld    = r_vld[C_ID_AMP];
    assign o_p2p_vld    = r_vld[C_ID_P2P];
    assign o_offset_vld = r_vld[C_ID_OFFSET];
    assign o_phase_vld  = r_vld[C_ID_PHASE];
    assign o_duty_vld   = r_vld[C_ID_DUTY];
    assign o_err        = r_err;
    assign o_err_code   = r_err_code;
    assign o_ok_cnt     = r_ok_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_dds_cmd_parser.sv
// Directed bench for dds_cmd_parser with hand-computed expectations.
module tb_dds_cmd_parser;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        i_rx_last = 1'b0;
    logic        o_dds_run;
    logic [2:0]  o_dds_type;
    logic [15:0] o_dds_frq;
    logic [11:0] o_dds_amp;
    logic [12:0] o_dds_p2p;
    logic [12:0] o_dds_offset;
    logic [11:0] o_dds_phase;
    logic [9:0]  o_dds_duty;
    logic [1:0]  o_run_vld, o_type_vld, o_frq_vld, o_amp_vld;
    logic [1:0]  o_p2p_vld, o_offset_vld, o_phase_vld, o_duty_vld;
    logic        o_err;
    logic [2:0]  o_err_code;
    logic [15:0] o_ok_cnt;
    logic [15:0] o_err_cnt;

    int n_total = 0;
    int n_bad   = 0;

    dds_cmd_parser #(
        .P_CH_NUM  (2),
        .P_TIMEOUT (1024)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .i_rx_last    (i_rx_last),
        .o_dds_run    (o_dds_run),
        .o_dds_type   (o_dds_type),
        .o_dds_frq    (o_dds_frq),
        .o_dds_amp    (o_dds_amp),
        .o_dds_p2p    (o_dds_p2p),
        .o_dds_offset (o_dds_offset),
        .o_dds_phase  (o_dds_phase),
        .o_dds_duty   (o_dds_duty),
        .o_run_vld    (o_run_vld),
        .o_type_vld   (o_type_vld),
        .o_frq_vld    (o_frq_vld),
        .o_amp_vld    (o_amp_vld),
        .o_p2p_vld    (o_p2p_vld),
        .o_offset_vld (o_offset_vld),
        .o_phase_vld  (o_phase_vld),
        .o_duty_vld   (o_duty_vld),
        .o_err        (o_err),
        .o_err_code   (o_err_code),
        .o_ok_cnt     (o_ok_cnt),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Present one byte for one clock; returns 1 time unit after the accepting edge
    task automatic put(input logic [7:0] b, input logic last);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        i_rx_last  = last;
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        i_rx_last  = 1'b0;
    endtask

    task automatic frame(input logic [7:0] ch, input logic [7:0] id, input logic [7:0] vh,
                         input logic [7:0] vl, input logic [7:0] cs, input logic last);
        put(8'h55, 1'b0);
        put(8'hAA, 1'b0);
        put(ch, 1'b0);
        put(id, 1'b0);
        put(vh, 1'b0);
        put(vl, 1'b0);
        put(cs, last);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_frq", 32'(o_dds_frq), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_code", 32'(o_err_code), 0);
        check("rst_okcnt", 32'(o_ok_cnt), 0);
        check("rst_frqvld", 32'(o_frq_vld), 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Frequency 50000 on ch0, with last on the CS byte
        frame(8'h00, 8'h02, 8'hC3, 8'h50, 8'h15, 1'b1);
        check("frq_val", 32'(o_dds_frq), 50000);
        check("frq_vld", 32'(o_frq_vld), 2'b01);
        check("frq_okcnt", 32'(o_ok_cnt), 1);
        check("frq_noerr", 32'(o_err), 0);
        @(posedge i_clk);
        #1;
        check("frq_vld_drop", 32'(o_frq_vld), 0);

        // Amplitude 3001 is out of range
        frame(8'h01, 8'h03, 8'h0B, 8'hB9, 8'hC8, 1'b0);
        check("amp_rng_vld", 32'(o_amp_vld), 0);
        check("amp_rng_err", 32'(o_err), 1);
        check("amp_rng_code", 32'(o_err_code), 4);
        check("amp_rng_hold", 32'(o_dds_amp), 0);
        check("amp_rng_errcnt", 32'(o_err_cnt), 1);
        @(posedge i_clk);
        #1;
        check("err_pulse_drop", 32'(o_err), 0);
        check("code_held", 32'(o_err_code), 4);

        // Amplitude 3000 is the inclusive limit
        frame(8'h00, 8'h03, 8'h0B, 8'hB8, 8'hC6, 1'b0);
        check("amp_lim_val", 32'(o_dds_amp), 3000);
        check("amp_lim_vld", 32'(o_amp_vld), 2'b01);
        check("amp_lim_okcnt", 32'(o_ok_cnt), 2);

        // Broadcast run
        frame(8'hFF, 8'h00, 8'h00, 8'h01, 8'h00, 1'b0);
        check("bc_run", 32'(o_dds_run), 1);
        check("bc_vld", 32'(o_run_vld), 2'b11);
        check("bc_okcnt", 32'(o_ok_cnt), 3);

        // Same frame with a bad checksum
        frame(8'hFF, 8'h00, 8'h00, 8'h01, 8'h01, 1'b0);
        check("cs_code", 32'(o_err_code), 1);
        check("cs_vld", 32'(o_run_vld), 0);
        check("cs_errcnt", 32'(o_err_cnt), 2);

        // Channel 2 does not exist
        frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h02, 1'b0);
        check("ch_code", 32'(o_err_code), 2);
        check("ch_vld", 32'(o_run_vld), 0);

        // ID 8 is unknown
        frame(8'h00, 8'h08, 8'h00, 8'h00, 8'h08, 1'b0);
        check("id_code", 32'(o_err_code), 3);
        check("id_errcnt", 32'(o_err_cnt), 4);

        // Resync on junk/repeated header, then back-to-back frames
        put(8'h12, 1'b0);
        put(8'h55, 1'b0);
        frame(8'h00, 8'h07, 8'h01, 8'hF4, 8'hFC, 1'b0);
        check("duty_val", 32'(o_dds_duty), 500);
        check("duty_vld", 32'(o_duty_vld), 2'b01);
        put(8'h55, 1'b0);
        check("duty_vld_once", 32'(o_duty_vld), 0);
        put(8'hAA, 1'b0);
        put(8'h00, 1'b0);
        put(8'h06, 1'b0);
        put(8'h0E, 1'b0);
        put(8'h10, 1'b0);
        put(8'h24, 1'b0);
        check("phase_val", 32'(o_dds_phase), 3600);
        check("phase_vld", 32'(o_phase_vld), 2'b01);
        check("b2b_okcnt", 32'(o_ok_cnt), 5);

        // Truncation on the ID byte
        put(8'h55, 1'b0);
        put(8'hAA, 1'b0);
        put(8'h00, 1'b0);
        put(8'h02, 1'b1);
        check("trunc_err", 32'(o_err), 1);
        check("trunc_code", 32'(o_err_code), 5);
        check("trunc_errcnt", 32'(o_err_cnt), 5);
        frame(8'h01, 8'h02, 8'h03, 8'hE8, 8'hEE, 1'b0);
        check("post_trunc_frq", 32'(o_dds_frq), 1000);
        check("post_trunc_vld", 32'(o_frq_vld), 2'b10);
        check("post_trunc_okcnt", 32'(o_ok_cnt), 6);

        // Timeout after the CH byte: 1023 idle cycles are tolerated, the 1024th aborts
        put(8'h55, 1'b0);
        put(8'hAA, 1'b0);
        put(8'h00, 1'b0);
        repeat (1023) @(posedge i_clk);
        #1;
        check("to_early_err", 32'(o_err), 0);
        check("to_early_cnt", 32'(o_err_cnt), 5);
        @(posedge i_clk);
        #1;
        check("to_err", 32'(o_err), 1);
        check("to_code", 32'(o_err_code), 6);
        check("to_errcnt", 32'(o_err_cnt), 6);
        frame(8'h00, 8'h01, 8'h00, 8'h05, 8'h06, 1'b0);
        check("post_to_type", 32'(o_dds_type), 5);
        check("post_to_vld", 32'(o_type_vld), 2'b01);
        check("post_to_okcnt", 32'(o_ok_cnt), 7);

        // Asynchronous reset mid-frame
        put(8'h55, 1'b0);
        put(8'hAA, 1'b0);
        put(8'h00, 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_frq", 32'(o_dds_frq), 0);
        check("arst_type", 32'(o_dds_type), 0);
        check("arst_okcnt", 32'(o_ok_cnt), 0);
        check("arst_errcnt", 32'(o_err_cnt), 0);
        check("arst_code", 32'(o_err_code), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        frame(8'h01, 8'h05, 8'h17, 8'h70, 8'h8D, 1'b0);
        check("post_rst_offset", 32'(o_dds_offset), 6000);
        check("post_rst_vld", 32'(o_offset_vld), 2'b10);
        check("post_rst_okcnt", 32'(o_ok_cnt), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
